// File: rtl/scpad_types_pkg.sv
// ---------------------------------------------------------------------------
// scpad_types_pkg: shared scratchpad crossbar types and geometry. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package scpad_types_pkg;

  localparam int NUM_COLS      = 32;
  localparam int ELEM_WIDTH    = 16;
  localparam int MAX_DIM_WIDTH = $clog2(NUM_COLS);
  localparam int TAG_WIDTH     = 4;
  localparam int RSP_TAG_WIDTH = TAG_WIDTH;

  typedef struct packed {
    logic [NUM_COLS-1:0][MAX_DIM_WIDTH-1:0] shift_mask;
    logic [NUM_COLS-1:0]                    valid_mask;
  } xbar_desc_t;

  typedef logic [NUM_COLS-1:0][ELEM_WIDTH-1:0] lane_vec_t;

  typedef struct packed {
    lane_vec_t                data;
    logic [RSP_TAG_WIDTH-1:0] tag;
  } scpad_rsp_t;

endpackage

`default_nettype wire

// File: rtl/scpad_sync_fifo.sv
// ---------------------------------------------------------------------------
// scpad_sync_fifo: registered-head synchronous FIFO, zero output when empty. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module scpad_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == c_CNT_W'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop frees the head slot in the same cycle, so push into a full FIFO is legal then.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_dout    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= f_next(r_rd_ptr);
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/scpad_rsp_unswizzle.sv
// ---------------------------------------------------------------------------
// scpad_rsp_unswizzle: pairs bank read data with issued descriptors, de-swizzles
// lanes and buffers responses under credits. Option: SCPAD_RSP_ZERO_FILL_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module scpad_rsp_unswizzle
  import scpad_types_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_req_valid,
  output logic                           o_req_ready,
  input  xbar_desc_t                     i_req_desc,
  input  logic [TAG_WIDTH-1:0]           i_req_tag,
  input  logic                           i_bank_rvalid,
  input  logic [NUM_COLS*ELEM_WIDTH-1:0] i_bank_rdata,
  output logic                           o_rsp_valid,
  input  logic                           i_rsp_ready,
  output logic [NUM_COLS*ELEM_WIDTH-1:0] o_rsp_data,
  output logic [TAG_WIDTH-1:0]           o_rsp_tag,
  output logic                           o_busy,
  output logic                           o_err_orphan
);

  localparam int c_CRED_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int c_SHIFT_W = NUM_COLS * MAX_DIM_WIDTH;
`ifdef SCPAD_RSP_ZERO_FILL_EN
  localparam int c_DESC_W  = c_SHIFT_W + NUM_COLS + TAG_WIDTH;
`else
  localparam int c_DESC_W  = c_SHIFT_W + TAG_WIDTH;
`endif

  logic [c_CRED_W-1:0]                    r_credits;
  logic                                   r_err_orphan;
  logic                                   w_issue;
  logic                                   w_retire;
  logic [c_DESC_W-1:0]                    w_desc_din;
  logic [c_DESC_W-1:0]                    w_desc_dout;
  logic                                   w_desc_empty;
  logic                                   w_desc_full;
  logic [NUM_COLS-1:0][MAX_DIM_WIDTH-1:0] w_head_shift;
  logic [TAG_WIDTH-1:0]                   w_head_tag;
  lane_vec_t                              w_bank;
  lane_vec_t                              w_lanes;
  logic                                   w_rsp_push;
  scpad_rsp_t                             w_rsp_in;
  scpad_rsp_t                             w_rsp_out;
  logic                                   w_rsp_empty;
  logic                                   w_rsp_full;
  logic                                   w_unused_full;

  assign w_issue  = i_req_valid & o_req_ready;
  assign w_retire = o_rsp_valid & i_rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_credits <= c_CRED_W'(MAX_OUTSTANDING);
    end else if (w_issue && !w_retire) begin
      r_credits <= r_credits - 1'b1;
    end else if (w_retire && !w_issue) begin
      r_credits <= r_credits + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_orphan <= 1'b0;
    end else if (i_bank_rvalid && w_desc_empty) begin
      r_err_orphan <= 1'b1;
    end
  end

`ifdef SCPAD_RSP_ZERO_FILL_EN
  logic [NUM_COLS-1:0] w_head_valid;
  assign w_desc_din   = {i_req_desc.shift_mask, i_req_desc.valid_mask, i_req_tag};
  assign w_head_valid = w_desc_dout[TAG_WIDTH +: NUM_COLS];
`else
  logic w_unused_valid;
  assign w_desc_din     = {i_req_desc.shift_mask, i_req_tag};
  assign w_unused_valid = ^i_req_desc.valid_mask;
`endif
  assign w_head_shift = w_desc_dout[c_DESC_W-1 -: c_SHIFT_W];
  assign w_head_tag   = w_desc_dout[TAG_WIDTH-1:0];

  scpad_sync_fifo #(
    .WIDTH (c_DESC_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_desc_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_issue),
    .i_din   (w_desc_din),
    .i_pop   (i_bank_rvalid),
    .o_dout  (w_desc_dout),
    .o_full  (w_desc_full),
    .o_empty (w_desc_empty)
  );

  // The request-side XOR swizzle is self-inverse, so the stored shift index selects the bank directly.
  assign w_bank = i_bank_rdata;
  for (genvar j = 0; j < NUM_COLS; j++) begin : g_lane
`ifdef SCPAD_RSP_ZERO_FILL_EN
    assign w_lanes[j] = w_head_valid[j] ? w_bank[w_head_shift[j]] : '0;
`else
    assign w_lanes[j] = w_bank[w_head_shift[j]];
`endif
  end

  assign w_rsp_push    = i_bank_rvalid & ~w_desc_empty;
  assign w_rsp_in      = '{data: w_lanes, tag: w_head_tag};
  assign w_unused_full = w_desc_full | w_rsp_full;

  scpad_sync_fifo #(
    .WIDTH ($bits(scpad_rsp_t)),
    .DEPTH (MAX_OUTSTANDING)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rsp_push),
    .i_din   (w_rsp_in),
    .i_pop   (w_retire),
    .o_dout  (w_rsp_out),
    .o_full  (w_rsp_full),
    .o_empty (w_rsp_empty)
  );

  assign o_req_ready  = (r_credits != '0);
  assign o_busy       = (r_credits != c_CRED_W'(MAX_OUTSTANDING));
  assign o_rsp_valid  = ~w_rsp_empty;
  assign o_rsp_data   = w_rsp_out.data;
  assign o_rsp_tag    = w_rsp_out.tag;
  assign o_err_orphan = r_err_orphan;

endmodule

`default_nettype wire

// File: tb/tb_scpad_rsp_unswizzle.sv
// ---------------------------------------------------------------------------
// tb_scpad_rsp_unswizzle: directed scenarios plus random traffic against a queue model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_scpad_rsp_unswizzle;
  import scpad_types_pkg::*;

  localparam int MAX_OUT = 4;

  typedef struct packed {
    xbar_desc_t           d;
    logic [TAG_WIDTH-1:0] tag;
  } desc_ent_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  xbar_desc_t           req_desc = '0;
  logic [TAG_WIDTH-1:0] req_tag = '0;
  logic                 bank_rvalid = 1'b0;
  lane_vec_t            bank_rdata = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  lane_vec_t            rsp_data;
  logic [TAG_WIDTH-1:0] rsp_tag;
  logic                 busy;
  logic                 err_orphan;

  int n_tests = 0;
  int n_fail  = 0;

  desc_ent_t  m_desc_q[$];
  scpad_rsp_t m_rsp_q[$];
  int         m_credits = MAX_OUT;
  bit         m_err = 0;
  bit         m_live = 0;
  bit         m_iss, m_ret;
  desc_ent_t  m_e;

  scpad_rsp_unswizzle #(.MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_desc   (req_desc),
    .i_req_tag    (req_tag),
    .i_bank_rvalid(bank_rvalid),
    .i_bank_rdata (bank_rdata),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_data   (rsp_data),
    .o_rsp_tag    (rsp_tag),
    .o_busy       (busy),
    .o_err_orphan (err_orphan)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic lane_vec_t f_expect(input xbar_desc_t d, input lane_vec_t bank);
    lane_vec_t r;
    for (int j = 0; j < NUM_COLS; j++) begin
      r[j] = bank[d.shift_mask[j]];
`ifdef SCPAD_RSP_ZERO_FILL_EN
      if (!d.valid_mask[j]) r[j] = '0;
`endif
    end
    return r;
  endfunction

  // Reference model: queues of pending descriptors and buffered responses plus a credit count.
  always @(posedge clk) begin
    if (rst) begin
      m_desc_q.delete();
      m_rsp_q.delete();
      m_credits = MAX_OUT;
      m_err     = 0;
      m_live    = 1;
    end else if (m_live) begin
      m_iss = req_valid && (m_credits != 0);
      m_ret = (m_rsp_q.size() != 0) && rsp_ready;
      if (m_ret) void'(m_rsp_q.pop_front());
      if (bank_rvalid) begin
        if (m_desc_q.size() == 0) m_err = 1;
        else begin
          m_e = m_desc_q.pop_front();
          m_rsp_q.push_back('{data: f_expect(m_e.d, bank_rdata), tag: m_e.tag});
        end
      end
      if (m_iss) m_desc_q.push_back('{d: req_desc, tag: req_tag});
      m_credits = m_credits - int'(m_iss) + int'(m_ret);
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("req_ready", req_ready, m_credits != 0);
      check("busy", busy, m_credits != MAX_OUT);
      check("err_orphan", err_orphan, m_err);
      check("rsp_valid", rsp_valid, m_rsp_q.size() != 0);
      if (m_rsp_q.size() != 0) begin
        check("rsp_data", rsp_data, m_rsp_q[0].data);
        check("rsp_tag", rsp_tag, m_rsp_q[0].tag);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_desc();
    for (int j = 0; j < NUM_COLS; j++) req_desc.shift_mask[j] = MAX_DIM_WIDTH'($urandom);
    req_desc.valid_mask = $urandom;
  endtask

  task automatic rand_bank();
    for (int b = 0; b < NUM_COLS; b++) bank_rdata[b] = ELEM_WIDTH'($urandom);
  endtask

  initial begin
    tick();
    tick();
    check("reset_req_ready", req_ready, 1'b1);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_data", rsp_data, '0);
    check("reset_rsp_tag", rsp_tag, '0);
    check("reset_busy", busy, 1'b0);
    check("reset_err", err_orphan, 1'b0);
    rst = 1'b0;

    // Row read: shift j^3, all lanes valid, bank b holds b+100.
    for (int j = 0; j < NUM_COLS; j++) req_desc.shift_mask[j] = MAX_DIM_WIDTH'(j ^ 3);
    req_desc.valid_mask = '1;
    req_tag = 4'd5;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int b = 0; b < NUM_COLS; b++) bank_rdata[b] = ELEM_WIDTH'(b + 100);
    bank_rvalid = 1'b1;
    check("row_pre_valid", rsp_valid, 1'b0);
    tick();
    bank_rvalid = 1'b0;
    check("row_valid", rsp_valid, 1'b1);
    check("row_tag", rsp_tag, 4'd5);
    check("row_lane0", rsp_data[0], 16'd103);
    check("row_lane5", rsp_data[5], 16'd106);
    check("row_lane31", rsp_data[31], 16'd128);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("row_retired", rsp_valid, 1'b0);

    // Column read: five valid lanes, shift 7^j, bank b holds 3b+1.
    for (int j = 0; j < NUM_COLS; j++) req_desc.shift_mask[j] = MAX_DIM_WIDTH'(j ^ 7);
    req_desc.valid_mask = 32'h1F;
    req_tag = 4'd9;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int b = 0; b < NUM_COLS; b++) bank_rdata[b] = ELEM_WIDTH'(3 * b + 1);
    bank_rvalid = 1'b1;
    tick();
    bank_rvalid = 1'b0;
    check("col_lane2", rsp_data[2], 16'd16);
    check("col_lane4", rsp_data[4], 16'd10);
`ifdef SCPAD_RSP_ZERO_FILL_EN
    check("col_lane10", rsp_data[10], 16'd0);
`else
    check("col_lane10", rsp_data[10], 16'd40);
`endif
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Four back-to-back issues with the consumer stalled, then drain.
    for (int t = 0; t < 4; t++) begin
      rand_desc();
      req_tag = 4'(t);
      req_valid = 1'b1;
      tick();
    end
    req_valid = 1'b0;
    check("full_req_ready", req_ready, 1'b0);
    check("full_busy", busy, 1'b1);
    for (int t = 0; t < 4; t++) begin
      rand_bank();
      bank_rvalid = 1'b1;
      tick();
    end
    bank_rvalid = 1'b0;
    tick();
    check("buf_valid", rsp_valid, 1'b1);
    check("buf_head_tag", rsp_tag, 4'd0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_valid", rsp_valid, 1'b1);
      check("drain_tag", rsp_tag, 4'(k));
      tick();
      if (k == 0) check("drain_credit_back", req_ready, 1'b1);
    end
    rsp_ready = 1'b0;
    check("drained", rsp_valid, 1'b0);

    // Out of credits: a request alongside a retire is dropped, then issue+retire holds credits.
    for (int t = 0; t < 4; t++) begin
      rand_desc();
      req_tag = 4'(t);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      rand_bank();
      bank_rvalid = 1'b1;
      tick();
      bank_rvalid = 1'b0;
    end
    check("c0_ready", req_ready, 1'b0);
    rand_desc();
    req_tag = 4'hA;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    tick();
    check("c0_drop_ready", req_ready, 1'b1);
    req_tag = 4'hB;
    tick();
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check("c1_hold_ready", req_ready, 1'b1);
    check("c1_head_tag", rsp_tag, 4'd2);
    rand_bank();
    bank_rvalid = 1'b1;
    tick();
    bank_rvalid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    rsp_ready = 1'b0;
    check("c_idle_busy", busy, 1'b0);

    // Orphan return.
    bank_rvalid = 1'b1;
    tick();
    bank_rvalid = 1'b0;
    check("orphan_err", err_orphan, 1'b1);
    check("orphan_no_rsp", rsp_valid, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("orphan_cleared", err_orphan, 1'b0);

    // Reset with three requests outstanding.
    for (int t = 0; t < 3; t++) begin
      rand_desc();
      req_tag = 4'(t);
      req_valid = 1'b1;
      tick();
    end
    req_valid = 1'b0;
    rand_bank();
    bank_rvalid = 1'b1;
    tick();
    bank_rvalid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    tick();
    check("rst_still_empty", rsp_valid, 1'b0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rand_desc();
      rand_bank();
      req_tag     = 4'($urandom);
      req_valid   = ($urandom_range(0, 1) == 1);
      rsp_ready   = ($urandom_range(0, 9) < 6);
      bank_rvalid = (m_desc_q.size() != 0) && ($urandom_range(0, 9) < 4);
      rst         = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      rand_bank();
      bank_rvalid = (m_desc_q.size() != 0);
      tick();
    end
    bank_rvalid = 1'b0;
    tick();
    check("final_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
